// File: rtl/vga_timing_gen.sv
// VGA timing generator, 640x480 @ 60 Hz by default, one pixel per vga_clk.
//
// Free-running horizontal/vertical counters are decoded into scan coordinates,
// an active-display enable and line/frame start pulses, all registered. The
// hs/vs sync pins get SYNC_DELAY extra register stages so their edges line up
// with colour from a renderer whose pipeline is that many cycles deep.
//
// Ports:
//   vga_clk     in   pixel clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   DrawX       out  current pixel column, 0..H_TOTAL-1
//   DrawY       out  current line, 0..V_TOTAL-1
//   blank       out  1 = active display area, 0 = blanking
//   hs          out  horizontal sync, active low, delayed by SYNC_DELAY
//   vs          out  vertical sync, active low, delayed by SYNC_DELAY
//   frame_start out  one-cycle pulse at DrawX=0, DrawY=0
//   line_start  out  one-cycle pulse at DrawX=0
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_DELAY = 2   // 0..4
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HMax       = 10'(H_TOTAL - 1);
  localparam logic [9:0] VMax       = 10'(V_TOTAL - 1);
  localparam logic [9:0] HActive    = 10'(H_ACTIVE);
  localparam logic [9:0] VActive    = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hc_wrap;

  logic       blank_d;
  logic       line_start_d;
  logic       frame_start_d;
  logic       hs_raw;
  logic       vs_raw;

  // Index 0 is the output register, 1..SYNC_DELAY are the delay stages.
  logic [SYNC_DELAY:0] hs_pipe_q;
  logic [SYNC_DELAY:0] vs_pipe_q;

  // Counter next state: vc advances only when hc wraps, both wrap together.
  always_comb begin
    hc_wrap = (hc_q == HMax);
    hc_d    = hc_wrap ? 10'd0 : hc_q + 10'd1;
    vc_d    = vc_q;
    if (hc_wrap) begin
      vc_d = (vc_q == VMax) ? 10'd0 : vc_q + 10'd1;
    end
  end

  // Output decode from the current counter state.
  always_comb begin
    blank_d       = (hc_q < HActive) && (vc_q < VActive);
    line_start_d  = (hc_q == 10'd0);
    frame_start_d = (hc_q == 10'd0) && (vc_q == 10'd0);
    hs_raw        = !((hc_q >= HSyncStart) && (hc_q < HSyncEnd));
    // vs covers whole lines, so it depends on vc only.
    vs_raw        = !((vc_q >= VSyncStart) && (vc_q < VSyncEnd));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q        <= 10'd0;
      vc_q        <= 10'd0;
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      DrawX       <= hc_q;
      DrawY       <= vc_q;
      blank       <= blank_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
    end
  end

  // Sync output register plus delay line; all stages reset inactive (high).
  if (SYNC_DELAY > 0) begin : g_sync_delay
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_pipe_q <= '1;
        vs_pipe_q <= '1;
      end else begin
        hs_pipe_q <= {hs_pipe_q[SYNC_DELAY-1:0], hs_raw};
        vs_pipe_q <= {vs_pipe_q[SYNC_DELAY-1:0], vs_raw};
      end
    end
  end else begin : g_sync_nodelay
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_pipe_q <= '1;
        vs_pipe_q <= '1;
      end else begin
        hs_pipe_q <= hs_raw;
        vs_pipe_q <= vs_raw;
      end
    end
  end

  assign hs = hs_pipe_q[SYNC_DELAY];
  assign vs = vs_pipe_q[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size instance with SYNC_DELAY=2,
// a full-size instance with SYNC_DELAY=0, and a shrunken-timing instance
// (15x8 total, SYNC_DELAY=0) so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  logic [9:0] d2_x, d2_y, d0_x, d0_y, ds_x, ds_y;
  logic d2_blank, d2_hs, d2_vs, d2_fs, d2_ls;
  logic d0_blank, d0_hs, d0_vs, d0_fs, d0_ls;
  logic ds_blank, ds_hs, ds_vs, ds_fs, ds_ls;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(.SYNC_DELAY(2)) u_d2 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d2_x), .DrawY(d2_y), .blank(d2_blank),
    .hs(d2_hs), .vs(d2_vs), .frame_start(d2_fs), .line_start(d2_ls)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d0_x), .DrawY(d0_y), .blank(d0_blank),
    .hs(d0_hs), .vs(d0_vs), .frame_start(d0_fs), .line_start(d0_ls)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(0)
  ) u_ds (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(ds_x), .DrawY(ds_y), .blank(ds_blank),
    .hs(ds_hs), .vs(ds_vs), .frame_start(ds_fs), .line_start(ds_ls)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    int unsigned ex, ey, hs_low, cnt, vs_low, blank_cnt, prev_y;
    logic h1, h2, raw;

    // Reset held: outputs stay at reset values across edges.
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_x", 32'(d2_x), 0);
      chk("rst_y", 32'(d2_y), 0);
      chk("rst_blank", 32'(d2_blank), 0);
      chk("rst_hs", 32'(d2_hs), 1);
      chk("rst_vs", 32'(d2_vs), 1);
      chk("rst_fs", 32'(d2_fs), 0);
      chk("rst_ls", 32'(d2_ls), 0);
      chk("rst_d0_hs", 32'(d0_hs), 1);
    end

    @(negedge vga_clk);
    reset_n = 1'b1;
    step();
    chk("first_x", 32'(d2_x), 0);
    chk("first_y", 32'(d2_y), 0);
    chk("first_blank", 32'(d2_blank), 1);
    chk("first_fs", 32'(d2_fs), 1);
    chk("first_ls", 32'(d2_ls), 1);

    // Two full lines plus part of a third, every cycle checked.
    ex = 0; ey = 0; h1 = 1'b1; h2 = 1'b1; hs_low = 0;
    for (int n = 0; n < 2 * 800 + 417; n++) begin
      raw = !(ex >= 656 && ex < 752);
      chk("line_x", 32'(d2_x), ex);
      chk("line_y", 32'(d2_y), ey);
      chk("line_blank", 32'(d2_blank), 32'(ex < 640 && ey < 480));
      chk("line_ls", 32'(d2_ls), 32'(ex == 0));
      chk("line_fs", 32'(d2_fs), 32'(ex == 0 && ey == 0));
      chk("line_hs_dly2", 32'(d2_hs), 32'(h2));
      chk("line_hs_dly0", 32'(d0_hs), 32'(raw));
      chk("line_vs_dly2", 32'(d2_vs), 1);
      chk("line_d0_x", 32'(d0_x), ex);
      if (!d2_hs) hs_low++;
      h2 = h1;
      h1 = raw;
      if (ex == 799) begin
        ex = 0;
        ey = ey + 1;
      end else begin
        ex = ex + 1;
      end
      step();
    end
    chk("hs_low_cycles", hs_low, 192);

    // Mid-line asynchronous reset, between edges.
    chk("pre_rst_x", 32'(d2_x), 417);
    chk("pre_rst_y", 32'(d2_y), 2);
    chk("pre_rst_blank", 32'(d2_blank), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_x", 32'(d2_x), 0);
    chk("async_y", 32'(d2_y), 0);
    chk("async_blank", 32'(d2_blank), 0);
    chk("async_hs", 32'(d2_hs), 1);
    chk("async_vs", 32'(d2_vs), 1);
    chk("async_fs", 32'(d2_fs), 0);
    chk("async_ls", 32'(d2_ls), 0);
    chk("async_d0_x", 32'(d0_x), 0);
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    step();
    chk("restart_x", 32'(d2_x), 0);
    chk("restart_y", 32'(d2_y), 0);
    chk("restart_blank", 32'(d2_blank), 1);
    chk("restart_fs", 32'(d2_fs), 1);
    chk("restart_ls", 32'(d2_ls), 1);
    chk("restart_small_fs", 32'(ds_fs), 1);

    // Small-timing instance: two whole frames, 15*8 = 120 cycles each.
    for (int f = 0; f < 2; f++) begin
      cnt = 0; vs_low = 0; blank_cnt = 0; prev_y = 32'(ds_y);
      while (cnt < 300) begin
        if (!ds_vs) vs_low++;
        if (ds_blank) blank_cnt++;
        if (ds_y == 10'd5 && ds_x == 10'd0) chk("small_vs_fall", 32'(ds_vs), 0);
        if (ds_y == 10'd4 && ds_x == 10'd14) chk("small_vs_before", 32'(ds_vs), 1);
        prev_y = 32'(ds_y);
        step();
        cnt++;
        if (ds_fs) break;
      end
      chk("small_frame_period", cnt, 120);
      chk("small_last_y", prev_y, 7);
      chk("small_wrap_y", 32'(ds_y), 0);
      chk("small_wrap_x", 32'(ds_x), 0);
      chk("small_vs_low", vs_low, 30);
      chk("small_blank_cnt", blank_cnt, 32);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running VGA timing generator for 640x480 at 60 Hz, one pixel per vga_clk (25 MHz).
- Sits directly upstream of the sprite/background renderers.
- Supplies the DrawX/DrawY scan coordinates and the active-display "blank" enable that renderers consume.
- Drives the hs/vs sync pins through a configurable delay line. The delay compensates for the renderer's ROM-read plus output-register latency, so sync edges line up with the colour outputs.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_DELAY, 2, extra vga_clk cycles applied to hs/vs only (legal range 0..4)

Ports:
vga_clk  input  1  pixel clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
DrawX  output  10  current pixel column, 0..H_TOTAL-1
DrawY  output  10  current line, 0..V_TOTAL-1
blank  output  1  1 = active display area (renderer drives colour), 0 = blanking
hs  output  1  horizontal sync, active low, delayed by SYNC_DELAY
vs  output  1  vertical sync, active low, delayed by SYNC_DELAY
frame_start  output  1  one-cycle pulse when DrawX=0 and DrawY=0
line_start  output  1  one-cycle pulse whenever DrawX=0

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Internal counters hc and vc, 10 bits each:
  - hc increments every cycle and wraps H_TOTAL-1 -> 0.
  - vc increments only on the cycle hc wraps, and itself wraps V_TOTAL-1 -> 0 in that same cycle.
- All outputs are registered. On each edge, outputs are loaded from the current (hc,vc) and the counters advance. This gives one cycle from counter state to output.
- Output decode:
  - DrawX = hc, DrawY = vc.
  - blank = (hc < H_ACTIVE) && (vc < V_ACTIVE).
  - line_start = (hc == 0).
  - frame_start = (hc == 0) && (vc == 0).
- Raw sync before the delay line:
  - hs_raw = 0 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw = 0 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491, for the whole line including hc=0..799.
- Sync delay line:
  - hs/vs pass through a SYNC_DELAY-stage shift register after the output register.
  - SYNC_DELAY=0 means hs/vs are cycle-aligned with DrawX/blank.
  - DrawX, DrawY, blank, line_start and frame_start are never delayed.
- Reset, applied asynchronously while reset_n=0:
  - hc=vc=0; DrawX=0, DrawY=0.
  - blank=0, frame_start=0, line_start=0.
  - hs=1, vs=1, and every delay-line stage = 1 (inactive).
- First rising edge after reset_n rises: DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1.
- Reset asserted mid-frame: all outputs go to their reset values immediately, without waiting for an edge. After release, the frame restarts from (0,0) as above; no partial frame state is retained.
- Simultaneous wrap: at hc=799 and vc=524, both counters wrap on the same edge. The next output cycle is (0,0) with frame_start=1.
- Frame period: exactly H_TOTAL*V_TOTAL = 420000 cycles between frame_start pulses.
- Line period: exactly 800 cycles between line_start pulses.
- Counter arithmetic is unsigned, 10 bits. No value outside 0..H_TOTAL-1 or 0..V_TOTAL-1 ever appears on DrawX/DrawY.

Test Plan:
- Reset check: hold reset_n=0, toggle vga_clk for 5 cycles -> DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_start=0 throughout. First edge after release -> DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1.
- Line timing: run one line with SYNC_DELAY=2 ->
  - blank=1 for DrawX 0..639 and 0 for 640..799.
  - hs=0 exactly during the 96 cycles that begin 2 cycles after DrawX=656 appears.
  - DrawX 799 is followed by DrawX=0 with DrawY incremented by 1.
- Frame wrap: run 2 frames ->
  - frame_start pulses are exactly 420000 cycles apart.
  - DrawY 524 is followed by DrawY=0.
  - blank=0 for all of DrawY 480..524.
  - vs=0 for exactly 1600 cycles, lines 490..491, shifted by 2 cycles.
- Zero delay: rebuild with SYNC_DELAY=0 -> hs falls on the same cycle DrawX=656 is presented; vs falls on the same cycle DrawY=490, DrawX=0 is presented.
- Mid-frame reset: assert reset_n=0 asynchronously at DrawY=300, DrawX=417, between clock edges -> outputs take reset values before the next edge. After release, DrawX=0, DrawY=0, frame_start=1, and the next frame_start comes 420000 cycles later.
- Renderer alignment: connect to the tank sprite renderer, SYNC_DELAY=2 -> the colour output is nonzero only while the 2-cycle-delayed blank would be 1, and hs falls 2 cycles after DrawX=656.
